// File: rtl/sipo_deser.sv
// sipo_deser: serial-to-parallel deserializer with a DEPTH-word output FIFO
module sipo_deser #(
   parameter int WIDTH     = 8,
   parameter int DEPTH     = 4,
   parameter int MSB_FIRST = 1
) (
   input  logic                     clk_i,
   input  logic                     rst_i,
   input  logic                     clr_i,
   input  logic                     sdata_i,
   input  logic                     svalid_i,
   output logic                     sready_o,
   output logic [WIDTH-1:0]         pdata_o,
   output logic                     pvalid_o,
   input  logic                     pready_i,
   output logic [$clog2(DEPTH):0]   level_o
);
   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam int AW = $clog2(DEPTH);
   localparam int LW = AW + 1;
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
   localparam logic [LW-1:0] FULL = LW'(DEPTH);
   typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_STALL} state_t;
   state_t           state;
   logic [CW-1:0]    bit_cnt, cnt_n;
   logic [WIDTH-1:0] sh, sh_n;
   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr, rd_ptr;
   logic [LW-1:0]    lvl_n;
   logic             acc, push, pop;
   assign sready_o = state != S_STALL;
   assign pvalid_o = level_o != '0;
   assign pdata_o  = pvalid_o ? mem[rd_ptr] : '0;
   always_comb begin
      acc   = svalid_i && sready_o && !clr_i;
      push  = acc && bit_cnt == LAST;
      pop   = pvalid_o && pready_i;
      sh_n  = (MSB_FIRST != 0) ? {sh[WIDTH-2:0], sdata_i} : {sdata_i, sh[WIDTH-1:1]};
      cnt_n = clr_i ? '0 : !acc ? bit_cnt : push ? '0 : bit_cnt + 1'b1;
      lvl_n = level_o + LW'(push) - LW'(pop);
   end
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state   <= S_IDLE;
         bit_cnt <= '0;
         sh      <= '0;
         wr_ptr  <= '0;
         rd_ptr  <= '0;
         level_o <= '0;
      end else begin
         state   <= cnt_n == '0 ? S_IDLE : (cnt_n == LAST && lvl_n == FULL) ? S_STALL : S_SHIFT;
         bit_cnt <= cnt_n;
         level_o <= lvl_n;
         if (clr_i) sh <= '0;
         else if (acc) sh <= sh_n;
         if (push) begin
            mem[wr_ptr] <= sh_n;
            wr_ptr      <= wr_ptr + 1'b1;
         end
         if (pop) rd_ptr <= rd_ptr + 1'b1;
      end
   end
endmodule

// File: tb/tb_sipo_deser.sv
// tb_sipo_deser: randomized check of MSB- and LSB-first instances against a word-queue model
module tb_sipo_deser;
   localparam int W = 8;
   localparam int D = 4;
   logic clk = 1'b0;
   logic rst, clr, svalid, sdata, pready;
   logic sready_m, sready_l, pvalid_m, pvalid_l;
   logic [W-1:0] pdata_m, pdata_l;
   logic [$clog2(D):0] level_m, level_l;
   int n_tests = 0;
   int n_fail = 0;
   int k = 0;
   logic [W-1:0] bits = '0;
   logic [W-1:0] qm[$];
   logic [W-1:0] ql[$];

   always #5 clk = ~clk;

   sipo_deser #(.WIDTH(W), .DEPTH(D), .MSB_FIRST(1)) u_msb (
      .clk_i(clk), .rst_i(rst), .clr_i(clr), .sdata_i(sdata), .svalid_i(svalid),
      .sready_o(sready_m), .pdata_o(pdata_m), .pvalid_o(pvalid_m), .pready_i(pready),
      .level_o(level_m));
   sipo_deser #(.WIDTH(W), .DEPTH(D), .MSB_FIRST(0)) u_lsb (
      .clk_i(clk), .rst_i(rst), .clr_i(clr), .sdata_i(sdata), .svalid_i(svalid),
      .sready_o(sready_l), .pdata_o(pdata_l), .pvalid_o(pvalid_l), .pready_i(pready),
      .level_o(level_l));

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic logic exp_sready();
      return !(k == W - 1 && qm.size() == D);
   endfunction

   task automatic check_all();
      chk("level_m", level_m, qm.size());
      chk("level_l", level_l, ql.size());
      chk("pvalid_m", pvalid_m, qm.size() != 0);
      chk("pvalid_l", pvalid_l, ql.size() != 0);
      chk("pdata_m", pdata_m, qm.size() != 0 ? qm[0] : 8'h00);
      chk("pdata_l", pdata_l, ql.size() != 0 ? ql[0] : 8'h00);
      chk("sready_m", sready_m, exp_sready());
      chk("sready_l", sready_l, exp_sready());
   endtask

   task automatic model(input logic r, c, v, d, p);
      logic sr;
      logic [W-1:0] wm, wl;
      if (r) begin
         k = 0;
         qm.delete();
         ql.delete();
         return;
      end
      sr = exp_sready();
      if (p && qm.size() != 0) begin
         void'(qm.pop_front());
         void'(ql.pop_front());
      end
      if (c) k = 0;
      else if (v && sr) begin
         bits[k] = d;
         k++;
         if (k == W) begin
            for (int i = 0; i < W; i++) begin
               wm[W-1-i] = bits[i];
               wl[i] = bits[i];
            end
            qm.push_back(wm);
            ql.push_back(wl);
            k = 0;
         end
      end
   endtask

   task automatic step(input logic r, c, v, d, p);
      check_all();
      rst = r; clr = c; svalid = v; sdata = d; pready = p;
      model(r, c, v, d, p);
      @(negedge clk);
   endtask

   task automatic send_word(input logic [W-1:0] w, input logic p);
      for (int i = 0; i < W; i++) step(1'b0, 1'b0, 1'b1, w[W-1-i], p);
   endtask

   task automatic drain();
      for (int i = 0; i < D + 2; i++) step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
   endtask

   initial begin
      logic [W-1:0] w;
      int got;
      rst = 1'b1; clr = 1'b0; svalid = 1'b0; sdata = 1'b0; pready = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      step(1'b1, 1'b0, 1'b1, 1'b1, 1'b1);
      chk("rst_level", level_m, 0);
      chk("rst_sready", sready_m, 1);
      chk("rst_pdata", pdata_m, 0);
      // basic word, palindrome in both bit orders
      send_word(8'hA5, 1'b1);
      chk("a5_pvalid", pvalid_m, 1);
      chk("a5_msb", pdata_m, 8'hA5);
      chk("a5_lsb", pdata_l, 8'hA5);
      step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      chk("a5_level0", level_m, 0);
      send_word(8'h80, 1'b0);
      chk("one_msb", pdata_m, 8'h80);
      chk("one_lsb", pdata_l, 8'h01);
      drain();
      // backpressure: full buffer stalls the last bit
      for (int n = 0; n < D; n++) send_word(8'($urandom), 1'b0);
      w = 8'($urandom);
      for (int i = 0; i < W - 1; i++) step(1'b0, 1'b0, 1'b1, w[W-1-i], 1'b0);
      chk("bp_level", level_m, D);
      chk("bp_sready", sready_m, 0);
      for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b1, w[0], 1'b0);
      chk("bp_hold", level_m, D);
      step(1'b0, 1'b0, 1'b1, w[0], 1'b1);
      chk("bp_pop", level_m, D - 1);
      step(1'b0, 1'b0, 1'b1, w[0], 1'b0);
      chk("bp_push5", level_m, D);
      drain();
      // gapped input
      got = 0;
      w = 8'($urandom);
      for (int t = 0; t < 200 && got < W; t++) begin
         if ($urandom_range(1, 0) == 1) begin
            step(1'b0, 1'b0, 1'b1, w[W-1-got], 1'b0);
            got++;
         end else step(1'b0, 1'b0, 1'b0, 1'($urandom), 1'b0);
      end
      chk("gap_bits", got, W);
      chk("gap_word", pdata_m, w);
      drain();
      // clear mid-word
      for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
      step(1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
      send_word(8'h3C, 1'b0);
      chk("clr_level", level_m, 1);
      chk("clr_word", pdata_m, 8'h3C);
      drain();
      // reset with data buffered and a partial word
      for (int n = 0; n < 3; n++) send_word(8'($urandom), 1'b0);
      for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 1'b1, 1'($urandom), 1'b0);
      chk("pre_rst_level", level_m, 3);
      step(1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
      chk("post_rst_level", level_m, 0);
      chk("post_rst_pvalid", pvalid_m, 0);
      chk("post_rst_sready", sready_m, 1);
      send_word(8'h5E, 1'b0);
      chk("post_rst_word", pdata_m, 8'h5E);
      drain();
      // random traffic
      for (int t = 0; t < 3000; t++)
         step($urandom_range(199, 0) == 0, $urandom_range(29, 0) == 0,
              $urandom_range(3, 0) != 0, 1'($urandom), 1'($urandom));
      check_all();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
